// File: rtl/stopwatch_lap_cu.sv
// Stopwatch run/stop/clear control unit with a lap capture FIFO.
// Lap entries are read through a pop port.
module stopwatch_lap_cu #(
  parameter int TIME_W    = 24,
  parameter int LAP_DEPTH = 8,
  parameter int CLR_PULSE = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_runstop,
  input  logic                           i_clear,
  input  logic                           i_lap,
  input  logic [TIME_W-1:0]              i_time,
  input  logic                           i_lap_rd,
  output logic                           o_runstop,
  output logic                           o_clear,
  output logic [1:0]                     o_state,
  output logic [TIME_W-1:0]              o_lap_time,
  output logic                           o_lap_valid,
  output logic [$clog2(LAP_DEPTH+1)-1:0] o_lap_count,
  output logic                           o_lap_full,
  output logic                           o_lap_ovf
);

  localparam int PW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH+1);
  localparam int KW = $clog2(CLR_PULSE+1);

  localparam logic [1:0] STOP  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] CLEAR = 2'b10;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [KW-1:0]     kcnt;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [TIME_W-1:0] mem [LAP_DEPTH];

  logic enter_clr;
  logic lap_req;
  logic pop;
  logic push;
  logic full;
  logic valid;

  assign valid     = (count != '0);
  assign full      = (count == CW'(LAP_DEPTH));
  assign enter_clr = (state == STOP) && !i_runstop && i_clear;
  assign lap_req   = (state == RUN) && !i_runstop && i_lap;
  assign pop       = i_lap_rd && valid;
  // a pop frees a slot in the same edge, so a full FIFO still accepts it
  assign push      = lap_req && (!full || pop);

  always_comb begin
    state_nx = state;
    unique case (state)
      STOP: begin
        if (i_runstop)    state_nx = RUN;
        else if (i_clear) state_nx = CLEAR;
      end
      RUN: begin
        if (i_runstop)    state_nx = STOP;
      end
      CLEAR: begin
        if (kcnt == KW'(CLR_PULSE-1)) state_nx = STOP;
      end
      default: state_nx = STOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= STOP;
      kcnt      <= '0;
      o_runstop <= 1'b0;
      o_clear   <= 1'b0;
    end else begin
      state     <= state_nx;
      kcnt      <= (state == CLEAR) ? kcnt + KW'(1) : '0;
      o_runstop <= (state == RUN);
      o_clear   <= (state == CLEAR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_lap_ovf <= 1'b0;
    end else if (enter_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_lap_ovf <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(LAP_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(LAP_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      if (lap_req && full && !pop)
        o_lap_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_time;
  end

  assign o_state     = state;
  assign o_lap_valid = valid;
  assign o_lap_count = count;
  assign o_lap_full  = full;
  assign o_lap_time  = valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_stopwatch_lap_cu.sv
// Directed bench for stopwatch_lap_cu with LAP_DEPTH=8, CLR_PULSE=3.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_stopwatch_lap_cu;

  localparam int TIME_W = 24;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              i_runstop, i_clear, i_lap, i_lap_rd;
  logic [TIME_W-1:0] i_time;
  logic              o_runstop, o_clear, o_lap_valid, o_lap_full, o_lap_ovf;
  logic [1:0]        o_state;
  logic [TIME_W-1:0] o_lap_time;
  logic [CW-1:0]     o_lap_count;

  int checks = 0;
  int errors = 0;

  stopwatch_lap_cu #(
    .TIME_W(TIME_W), .LAP_DEPTH(DEPTH), .CLR_PULSE(3)
  ) dut (
    .clk(clk), .reset(reset),
    .i_runstop(i_runstop), .i_clear(i_clear), .i_lap(i_lap),
    .i_time(i_time), .i_lap_rd(i_lap_rd),
    .o_runstop(o_runstop), .o_clear(o_clear), .o_state(o_state),
    .o_lap_time(o_lap_time), .o_lap_valid(o_lap_valid),
    .o_lap_count(o_lap_count), .o_lap_full(o_lap_full),
    .o_lap_ovf(o_lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_runstop = 0; i_clear = 0; i_lap = 0; i_lap_rd = 0;
  endtask

  task automatic pulse_runstop();
    i_runstop = 1; tick(); i_runstop = 0;
  endtask

  task automatic lap(input int t);
    i_lap = 1; i_time = TIME_W'(t); tick(); i_lap = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle(); i_time = '0;
    #12;
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL rst_state got %0d want 0", o_state); end
    checks++; if ({o_runstop, o_clear, o_lap_valid, o_lap_full, o_lap_ovf} !== 5'b0) begin
      errors++; $display("FAIL rst_flags got %b want 00000", {o_runstop, o_clear, o_lap_valid, o_lap_full, o_lap_ovf}); end
    checks++; if (o_lap_count !== '0) begin errors++; $display("FAIL rst_count got %0d want 0", o_lap_count); end
    @(posedge clk); #1; reset = 0;
    tick();
  endtask

  task automatic test_runstop();
    pulse_runstop();
    checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL run_state got %0d want 1", o_state); end
    checks++; if (o_runstop !== 1'b0) begin errors++; $display("FAIL run_lag got %b want 0", o_runstop); end
    tick();
    checks++; if (o_runstop !== 1'b1) begin errors++; $display("FAIL run_en got %b want 1", o_runstop); end
    repeat (6) tick();
    pulse_runstop();
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL stop_state got %0d want 0", o_state); end
    checks++; if (o_runstop !== 1'b1) begin errors++; $display("FAIL stop_lag got %b want 1", o_runstop); end
    tick();
    checks++; if (o_runstop !== 1'b0) begin errors++; $display("FAIL stop_en got %b want 0", o_runstop); end
  endtask

  task automatic test_clear();
    int highs = 0;
    i_clear = 1; tick(); i_clear = 0;
    checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL clr_state got %0d want 2", o_state); end
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL clr_lag got %b want 0", o_clear); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_clear === 1'b1) highs++;
    end
    checks++; if (highs !== 3) begin errors++; $display("FAIL clr_width got %0d want 3", highs); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL clr_end got %0d want 0", o_state); end
    pulse_runstop();
    i_clear = 1; tick(); i_clear = 0; tick();
    checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL clr_in_run got %0d want 1", o_state); end
    checks++; if (o_clear !== 1'b0) begin errors++; $display("FAIL clr_in_run_out got %b want 0", o_clear); end
    pulse_runstop();
  endtask

  task automatic test_laps();
    lap(7);
    checks++; if (o_lap_count !== '0) begin errors++; $display("FAIL lap_in_stop got %0d want 0", o_lap_count); end
    pulse_runstop();
    lap(100); lap(200); lap(300);
    i_runstop = 1; i_lap = 1; i_time = 999; tick(); idle();
    checks++; if (o_lap_count !== CW'(3)) begin errors++; $display("FAIL lap_count got %0d want 3", o_lap_count); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL lap_stop got %0d want 0", o_state); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (o_lap_time !== TIME_W'(100*i)) begin
        errors++; $display("FAIL lap_pop%0d got %0d want %0d", i, o_lap_time, 100*i); end
      i_lap_rd = 1; tick(); i_lap_rd = 0;
    end
    checks++; if (o_lap_valid !== 1'b0) begin errors++; $display("FAIL lap_valid got %b want 0", o_lap_valid); end
    i_lap_rd = 1; tick(); i_lap_rd = 0;
    checks++; if (o_lap_count !== '0) begin errors++; $display("FAIL pop_empty got %0d want 0", o_lap_count); end
  endtask

  task automatic test_full_ovf();
    pulse_runstop();
    for (int i = 0; i < 9; i++) lap(1000 + i);
    checks++; if (o_lap_count !== CW'(8)) begin errors++; $display("FAIL full_count got %0d want 8", o_lap_count); end
    checks++; if (o_lap_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", o_lap_full); end
    checks++; if (o_lap_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", o_lap_ovf); end
    i_lap = 1; i_lap_rd = 1; i_time = 5000; tick(); idle();
    checks++; if (o_lap_count !== CW'(8)) begin errors++; $display("FAIL pushpop_count got %0d want 8", o_lap_count); end
    pulse_runstop();
    for (int i = 0; i < 8; i++) begin
      int exp;
      exp = (i < 7) ? 1001 + i : 5000;
      checks++; if (o_lap_time !== TIME_W'(exp)) begin
        errors++; $display("FAIL full_pop%0d got %0d want %0d", i, o_lap_time, exp); end
      i_lap_rd = 1; tick(); i_lap_rd = 0;
    end
    checks++; if (o_lap_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", o_lap_ovf); end
    i_clear = 1; tick(); i_clear = 0;
    checks++; if (o_lap_ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b want 0", o_lap_ovf); end
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    pulse_runstop();
    for (int i = 0; i < 8; i++) lap(10 + i);
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_lap_time !== TIME_W'(10 + i)) begin
        errors++; $display("FAIL wrap_pop%0d got %0d want %0d", i, o_lap_time, 10 + i); end
      i_lap_rd = 1; tick(); i_lap_rd = 0;
    end
    for (int i = 0; i < 4; i++) lap(20 + i);
    checks++; if (o_lap_count !== CW'(7)) begin errors++; $display("FAIL wrap_count got %0d want 7", o_lap_count); end
    pulse_runstop();
    for (int i = 0; i < 5; i++) begin
      int exp;
      exp = (i < 3) ? 15 + i : 20 + (i - 3);
      checks++; if (o_lap_time !== TIME_W'(exp)) begin
        errors++; $display("FAIL wrap_tail%0d got %0d want %0d", i, o_lap_time, exp); end
      i_lap_rd = 1; tick(); i_lap_rd = 0;
    end
    i_clear = 1; i_lap_rd = 1; tick(); idle();
    checks++; if (o_lap_count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", o_lap_count); end
    checks++; if (o_lap_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", o_lap_valid); end
    repeat (4) tick();
    pulse_runstop(); lap(77); pulse_runstop();
    checks++; if (o_lap_time !== TIME_W'(77)) begin errors++; $display("FAIL post_flush got %0d want 77", o_lap_time); end
  endtask

  task automatic test_async_reset();
    pulse_runstop(); lap(55); pulse_runstop();
    i_clear = 1; tick(); i_clear = 0; tick();
    checks++; if (o_clear !== 1'b1) begin errors++; $display("FAIL arst_pre got %b want 1", o_clear); end
    #2 reset = 1;
    #1;
    checks++; if ({o_runstop, o_clear, o_lap_valid, o_lap_full, o_lap_ovf} !== 5'b0) begin
      errors++; $display("FAIL arst_flags got %b want 00000", {o_runstop, o_clear, o_lap_valid, o_lap_full, o_lap_ovf}); end
    checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL arst_state got %0d want 0", o_state); end
    checks++; if (o_lap_count !== '0 || o_lap_time !== '0) begin
      errors++; $display("FAIL arst_fifo got %0d/%0d want 0/0", o_lap_count, o_lap_time); end
    @(posedge clk); #1; reset = 0;
  endtask

  initial begin
    test_reset();
    test_runstop();
    test_clear();
    test_laps();
    test_full_ovf();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
